// File: rtl/uart_frame_tx_if.sv
// -----------------------------------------------------------------------------
// uart_frame_tx_if
// Bundles the word-input handshake and the byte-level transmitter handshake
// used by uart_frame_tx.
//   slave  : the framer (consumes words, drives the transmitter byte port)
//   master : the environment (feeds words, models the byte transmitter)
// Signals:
//   in_data/in_valid/in_ready : 64-bit word stream into the framer FIFO
//   tx_data/tx_start          : byte and one-cycle start pulse to transmitter
//   tx_busy/tx_done           : transmitter status and byte-complete pulse
//   frame_done                : pulse after the last byte of a frame completes
//   fifo_count/seq_num        : buffered word count, next frame sequence number
// -----------------------------------------------------------------------------
interface uart_frame_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          tx_done;
    logic          frame_done;
    logic [CW-1:0] fifo_count;
    logic [7:0]    seq_num;

    modport slave (
        input  in_data, in_valid, tx_busy, tx_done,
        output in_ready, tx_data, tx_start, frame_done, fifo_count, seq_num
    );

    modport master (
        output in_data, in_valid, tx_busy, tx_done,
        input  in_ready, tx_data, tx_start, frame_done, fifo_count, seq_num
    );
endinterface

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
// Buffers 64-bit words in a small FIFO and serialises each one as an 11-byte
// frame to a byte-level UART transmitter:
//   byte 0     : SYNC_BYTE
//   byte 1     : sequence number
//   byte 2..9  : word bytes, least significant first
//   byte 10    : XOR of bytes 1..9
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_frame_tx_if.slave (word input + transmitter byte interface)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a buffered word and an idle transmitter
// SEND  | present byte(byte_idx), pulse tx_start, fold byte into checksum
// WAIT  | hold tx_data until the transmitter reports tx_done
// GAP   | wait for tx_busy to drop before starting the next byte
// -----------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_frame_tx_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [63:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_in_ready;

    logic [63:0]     r_frame;
    logic [3:0]      r_byte_idx;
    logic [7:0]      r_csum;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            r_frame_done;
    logic [7:0]      r_seq;

    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;
    logic [2:0]      w_word_byte;
    logic [7:0]      w_cur_byte;

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !bus.tx_busy;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // in_ready is registered from the next count so it never depends on
    // in_valid combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != DEPTH_C);
        end
    end

    // Data byte index 2..9 maps to word byte 0..7; the low three bits of
    // byte_idx minus two give that mapping directly (8 -> 6, 9 -> 7).
    assign w_word_byte = r_byte_idx[2:0] - 3'd2;

    always_comb begin
        w_cur_byte = r_frame[{w_word_byte, 3'b000} +: 8];
        if (r_byte_idx == 4'd0) begin
            w_cur_byte = SYNC_BYTE;
        end else if (r_byte_idx == 4'd1) begin
            w_cur_byte = r_seq;
        end else if (r_byte_idx == 4'd10) begin
            w_cur_byte = r_csum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_frame      <= '0;
            r_byte_idx   <= '0;
            r_csum       <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            r_seq        <= '0;
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_frame    <= r_mem[r_rd_ptr];
                        r_byte_idx <= '0;
                        r_csum     <= '0;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_tx_data  <= w_cur_byte;
                    r_tx_start <= 1'b1;
                    if ((r_byte_idx >= 4'd1) && (r_byte_idx <= 4'd9)) begin
                        r_csum <= r_csum ^ w_cur_byte;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.tx_done) begin
                        if (r_byte_idx == 4'd10) begin
                            r_frame_done <= 1'b1;
                            r_seq        <= r_seq + 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_state    <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (!bus.tx_busy) begin
                        r_state <= S_SEND;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.frame_done = r_frame_done;
    assign bus.fifo_count = r_count;
    assign bus.seq_num    = r_seq;

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
// Bench for uart_frame_tx: a byte-transmitter model with configurable latency,
// post-done busy hold and spurious tx_done pulses; a frame reference built
// from pushed words; a table of known frames; and hand-written sequences for
// backpressure, sequence wrap and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_uart_frame_tx;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_tx_if #(.FIFO_DEPTH(DEPTH)) ifc();

    uart_frame_tx #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;

    logic m_busy = 1'b0;
    logic force_busy = 1'b0;
    assign ifc.tx_busy = m_busy | force_busy;

    int         lat = 20;
    int         post_hold = 0;
    bit         spur_en = 1'b0;
    int         m_cnt = 0;
    int         m_post = 0;
    bit         m_active = 1'b0;
    logic [7:0] m_held = '0;
    logic       m_prev_start = 1'b0;
    int         fd_count = 0;
    int         start_count = 0;

    logic [7:0]  cap_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  ref_seq = '0;

    typedef struct {
        logic [63:0]      word;
        logic [0:10][7:0] bytes;
        logic [7:0]       seq_after;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Transmitter model and protocol monitor, sampled 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_busy       = 1'b0;
            ifc.tx_done  = 1'b0;
            m_active     = 1'b0;
            m_cnt        = 0;
            m_post       = 0;
            m_prev_start = 1'b0;
        end else begin
            ifc.tx_done = 1'b0;
            if (ifc.frame_done) fd_count++;
            if (ifc.tx_start) begin
                chk("start_while_busy", 64'(ifc.tx_busy), 64'd0);
                chk("start_consecutive", 64'(m_prev_start), 64'd0);
                cap_q.push_back(ifc.tx_data);
                start_count++;
                m_active = 1'b1;
                m_cnt    = lat;
                m_held   = ifc.tx_data;
                m_busy   = 1'b1;
            end else if (m_active) begin
                chk("tx_data_stable", 64'(ifc.tx_data), 64'(m_held));
                m_cnt--;
                if (m_cnt == 0) begin
                    ifc.tx_done = 1'b1;
                    m_active    = 1'b0;
                    m_post      = post_hold;
                    m_busy      = (post_hold > 0);
                end
            end else begin
                if (m_post > 0) begin
                    m_post--;
                    m_busy = (m_post > 0);
                end
                if (spur_en && ($urandom_range(0, 3) == 0)) ifc.tx_done = 1'b1;
            end
            m_prev_start = ifc.tx_start;
        end
    end

    task automatic push(input logic [63:0] w, output bit acc);
        @(negedge clk);
        ifc.in_data  = w;
        ifc.in_valid = 1'b1;
        acc = ifc.in_ready;
        if (acc) exp_q.push_back(w);
    endtask

    task automatic push_wait(input logic [63:0] w);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 5000 && !a; k++) push(w, a);
        if (!a) fail_timeout("push_accept");
    endtask

    task automatic idle_in();
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int k = 0; k < budget && fd_count < n; k++) @(negedge clk);
        if (fd_count < n) fail_timeout("frame_done_wait");
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   64'(ifc.in_ready),   64'd1);
        chk({tag, "_tx_data"},    64'(ifc.tx_data),    64'd0);
        chk({tag, "_tx_start"},   64'(ifc.tx_start),   64'd0);
        chk({tag, "_frame_done"}, 64'(ifc.frame_done), 64'd0);
        chk({tag, "_fifo_count"}, 64'(ifc.fifo_count), 64'd0);
        chk({tag, "_seq_num"},    64'(ifc.seq_num),    64'd0);
    endtask

    // Reference: every accepted word becomes SYNC, seq, 8 bytes LSB first,
    // then the XOR of bytes 1..9; sequence numbers count up modulo 256.
    task automatic check_frames();
        int nf;
        logic [7:0] f[11];
        nf = exp_q.size();
        chk("byte_count", 64'(cap_q.size()), 64'(nf * 11));
        chk("frame_done_count", 64'(fd_count), 64'(nf));
        for (int fr = 0; fr < nf; fr++) begin
            f[0] = 8'hA5;
            f[1] = ref_seq;
            for (int i = 0; i < 8; i++) f[2 + i] = 8'(exp_q[fr] >> (8 * i));
            f[10] = '0;
            for (int i = 1; i <= 9; i++) f[10] = f[10] ^ f[i];
            for (int i = 0; i < 11; i++) begin
                if (fr * 11 + i < cap_q.size())
                    chk($sformatf("frame%0d_byte%0d", fr, i), 64'(cap_q[fr * 11 + i]), 64'(f[i]));
            end
            ref_seq = ref_seq + 8'd1;
        end
        chk("seq_num_after", 64'(ifc.seq_num), 64'(ref_seq));
        cap_q.delete();
        exp_q.delete();
        fd_count = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cap_q.delete();
        exp_q.delete();
        fd_count = 0;
        ref_seq  = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        int snap;
        bit a;
        logic [63:0] w;

        vecs[0].word = 64'h0123456789ABCDEF;
        vecs[0].bytes = {8'hA5, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
        vecs[0].seq_after = 8'h01;
        vecs[1].word = 64'h0123456789ABCDEF;
        vecs[1].bytes = {8'hA5, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h01};
        vecs[1].seq_after = 8'h02;
        vecs[2].word = 64'h0;
        vecs[2].bytes = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        vecs[2].seq_after = 8'h03;
        vecs[3].word = 64'h8000000000000001;
        vecs[3].bytes = {8'hA5, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h82};
        vecs[3].seq_after = 8'h04;

        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;

        // Known frames, 20-cycle transmitter latency.
        lat = 20;
        for (int v = 0; v < 4; v++) begin
            push_wait(vecs[v].word);
            idle_in();
            wait_frames(1, 2000);
            chk($sformatf("vec%0d_starts", v), 64'(cap_q.size()), 64'd11);
            for (int i = 0; i < 11; i++) begin
                if (i < cap_q.size())
                    chk($sformatf("vec%0d_byte%0d", v, i), 64'(cap_q[i]), 64'(vecs[v].bytes[i]));
            end
            chk($sformatf("vec%0d_frame_done", v), 64'(fd_count), 64'd1);
            chk($sformatf("vec%0d_seq", v), 64'(ifc.seq_num), 64'(vecs[v].seq_after));
            cap_q.delete();
            exp_q.delete();
            fd_count = 0;
            ref_seq = vecs[v].seq_after;
        end

        // Backpressure: transmitter held busy while five words are offered.
        @(negedge clk);
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom};
            push(w, a);
            chk($sformatf("bp_accept%0d", i), 64'(a), (i < 4) ? 64'd1 : 64'd0);
        end
        idle_in();
        chk("bp_fifo_full", 64'(ifc.fifo_count), 64'd4);
        chk("bp_in_ready_low", 64'(ifc.in_ready), 64'd0);
        snap = start_count;
        force_busy = 1'b0;
        for (int k = 0; k < 50 && start_count == snap; k++) @(negedge clk);
        if (start_count == snap) fail_timeout("bp_first_start");
        chk("bp_count_after_pop", 64'(ifc.fifo_count), 64'd3);
        chk("bp_in_ready_after_pop", 64'(ifc.in_ready), 64'd1);
        wait_frames(4, 8000);
        check_frames();

        // 257 zero words: sequence runs 00..FF and wraps to 00.
        do_reset();
        lat = 2;
        for (int i = 0; i < 257; i++) push_wait(64'h0);
        idle_in();
        wait_frames(257, 40000);
        check_frames();

        // Reset during byte 5 with two words still buffered.
        lat = 20;
        for (int i = 0; i < 3; i++) push_wait({$urandom, $urandom});
        idle_in();
        for (int k = 0; k < 2000 && cap_q.size() < 6; k++) @(negedge clk);
        if (cap_q.size() < 6) fail_timeout("reset_byte5_wait");
        chk("pre_reset_buffered", 64'(ifc.fifo_count), 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (3) @(negedge clk);
        cap_q.delete();
        exp_q.delete();
        fd_count = 0;
        ref_seq  = '0;
        rst_n = 1'b1;
        snap = start_count;
        repeat (40) @(negedge clk);
        chk("no_start_after_reset", 64'(start_count - snap), 64'd0);
        chk("fifo_empty_after_reset", 64'(ifc.fifo_count), 64'd0);
        push_wait({$urandom, $urandom});
        idle_in();
        wait_frames(1, 2000);
        check_frames();

        // Busy hold after done, spurious tx_done, random words and gaps.
        post_hold = 3;
        spur_en   = 1'b1;
        lat = $urandom_range(1, 6);
        for (int i = 0; i < 8; i++) begin
            push_wait({$urandom, $urandom});
            idle_in();
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_frames(8, 8000);
        check_frames();
        spur_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Upstream feeder for the byte-level UART transmitter.
- Accepts 64-bit delta/motif words on a valid/ready interface and buffers them in a small FIFO.
- Wraps each word in an 11-byte serial frame (sync, sequence, 8 data bytes LSB first, XOR checksum) and drives the transmitter's byte interface (data, start pulse, busy, done) one byte at a time.

Parameters:
- FIFO_DEPTH, 4, word FIFO depth; power of 2, minimum 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  64  delta word to frame
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept a word
- tx_data  output  8  byte to the transmitter
- tx_start  output  1  one-cycle start pulse to the transmitter
- tx_busy  input  1  transmitter busy
- tx_done  input  1  transmitter byte-complete pulse
- frame_done  output  1  one-cycle pulse after the last byte of a frame completes
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered
- seq_num  output  8  sequence number of the next frame to be sent

Behaviour:
- Interface: one clock domain (clk); rst_n is asynchronous, active-low; all outputs registered.
- Reset values:
  - in_ready=1, tx_data=0, tx_start=0, frame_done=0, fifo_count=0, seq_num=0.
  - FIFO empty, FSM in IDLE, checksum=0.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH), derived from registered count.
  - Pop only in IDLE when a frame starts.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Words are sent in push order.
  - in_valid while in_ready=0: ignored, no overflow state.
- Frame format, byte index 0..10:
  - 0: SYNC_BYTE.
  - 1: seq_num.
  - 2..9: word bits [7:0] .. [63:56].
  - 10: XOR of bytes 1..9.
- FSM states:
  - IDLE: when FIFO non-empty && tx_busy==0, latch the head word into the frame register, pop, set byte_idx=0, clear checksum, go to SEND.
  - SEND: drive tx_data=byte(byte_idx), assert tx_start for exactly this one cycle. If 1<=byte_idx<=9, set checksum ^= byte. Go to WAIT.
  - WAIT: hold tx_data stable and wait for tx_done.
    - On tx_done with byte_idx<10: byte_idx++, go to GAP.
    - On tx_done with byte_idx==10: pulse frame_done, seq_num++, go to IDLE.
  - GAP: wait until tx_busy==0, then go to SEND. This guarantees the transmitter has returned to idle before the next start.
- Handshake rules:
  - tx_start is never asserted while tx_busy==1.
  - tx_start is never asserted for two consecutive cycles.
  - tx_data is constant from the tx_start cycle until the matching tx_done.
  - tx_done outside WAIT is ignored.
- Timing:
  - At least 2 cycles between tx_done and the next tx_start.
  - Back-to-back frames: IDLE re-checks the FIFO in the cycle after frame_done, with no extra idle byte.
- seq_num is 8-bit and wraps 0xFF -> 0x00.
- Checksum: the byte-10 value is the final checksum register, including byte 9.
- Reset mid-frame:
  - Immediate return to reset values.
  - Partial frame and buffered words are discarded.
  - seq_num returns to 0.
  - The transmitter shares rst_n and recovers independently.
- Unknown or illegal FSM state: go to IDLE.

Test Plan:
1. Push 0x0123456789ABCDEF after reset; bench transmitter model asserts tx_done 20 cycles after each start -> tx_data sequence A5,00,EF,CD,AB,89,67,45,23,01,00; exactly 11 tx_start pulses; frame_done once; seq_num=1.
2. Push the same word again -> sequence A5,01,EF,CD,AB,89,67,45,23,01,01; seq_num=2.
3. Hold tx_busy=1 from reset and push 5 words back-to-back -> fifo_count=4, in_ready=0 after the 4th; the 5th is not accepted. Release tx_busy -> words emitted in push order; fifo_count decrements by 1 at each frame start; in_ready=1 after the first pop.
4. Push 257 zero words -> frames with seq bytes 00..FF, then 00 again; the checksum byte equals the seq byte in each frame.
5. Assert rst_n low during byte 5 of a frame with 2 words buffered -> outputs at reset values; fifo_count=0; no further tx_start; a new word after release produces a frame starting A5,00.
6. Model holds tx_busy high 3 cycles after each tx_done and drives tx_done pulses while in GAP/IDLE -> no tx_start while tx_busy=1; spurious tx_done ignored; frame bytes unchanged.
